// File: rtl/victory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : victory_pkg
// Brief    : Shared states, RGB332 field layout and helpers for the victory
//            overlay.
// Revision : 1.0 - initial release
// ============================================================================
package victory_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_reveal = 2'd1;
    localparam state_t c_st_hold   = 2'd2;

    localparam int c_r_msb = 7;
    localparam int c_r_lsb = 5;
    localparam int c_g_msb = 4;
    localparam int c_g_lsb = 2;
    localparam int c_b_msb = 1;
    localparam int c_b_lsb = 0;

    localparam logic [1:0] c_dim_max = 2'd3;

    function automatic int player_width(input int num_players);
        return (num_players <= 2) ? 1 : $clog2(num_players);
    endfunction

    function automatic int rom_addr_width(input int num_players, input int img_bits);
        return player_width(num_players) + 2 * img_bits;
    endfunction

    // Blue has only two bits, so its shift saturates at 2.
    function automatic logic [7:0] dim_shift(input logic [7:0] pix, input logic [1:0] dim);
        logic [2:0] w_r;
        logic [2:0] w_g;
        logic [1:0] w_b;
        logic [1:0] w_bs;
        w_bs = (dim > 2'd2) ? 2'd2 : dim;
        w_r  = pix[c_r_msb:c_r_lsb] >> dim;
        w_g  = pix[c_g_msb:c_g_lsb] >> dim;
        w_b  = pix[c_b_msb:c_b_lsb] >> w_bs;
        return {w_r, w_g, w_b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/victory_fade_timer.sv
`default_nettype none
// ============================================================================
// Module   : victory_fade_timer
// Brief    : Detects the start of each frame and emits a step pulse every
//            FADE_FRAMES frames while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module victory_fade_timer #(
    parameter int FADE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_pixel_row,
    input  logic [9:0] i_pixel_column,
    input  logic       i_enable,
    input  logic       i_clear,
    output logic       o_step
);

    localparam int c_cnt_w    = (FADE_FRAMES <= 1) ? 1 : $clog2(FADE_FRAMES);
    localparam int c_last_int = FADE_FRAMES - 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_last_int[c_cnt_w-1:0];

    logic               w_at_origin;
    logic               r_at_origin;
    logic               w_tick;
    logic [c_cnt_w-1:0] r_cnt;

    // Edge-detect the origin so a stalled raster still yields one tick per frame.
    assign w_at_origin = (i_pixel_row == 10'd0) && (i_pixel_column == 10'd0);
    assign w_tick      = w_at_origin && !r_at_origin;
    assign o_step      = i_enable && w_tick && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_at_origin <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_at_origin <= w_at_origin;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_enable && w_tick) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/victory_overlay.sv
`default_nettype none
// ============================================================================
// Module   : victory_overlay
// Brief    : Latches the winner, maps the raster onto the scaled winner image
//            and fades it in over a fixed number of frames.
// Revision : 1.0 - initial release
// ============================================================================
module victory_overlay
    import victory_pkg::*;
#(
    parameter int         NUM_PLAYERS = 2,
    parameter int         IMG_BITS    = 7,
    parameter int         SCALE_SHIFT = 2,
    parameter int         FADE_FRAMES = 8,
    parameter logic [7:0] BG_COLOR    = 8'h00
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          winner_valid,
    input  logic [player_width(NUM_PLAYERS)-1:0]          winner_id,
    input  logic                                          game_restart,
    input  logic [9:0]                                    pixel_row,
    input  logic [9:0]                                    pixel_column,
    output logic [rom_addr_width(NUM_PLAYERS, IMG_BITS)-1:0] rom_addr,
    input  logic [7:0]                                    rom_data,
    output logic [7:0]                                    data_out_v_s,
    output logic                                          dis_victory_screen
);

    localparam int c_pw       = player_width(NUM_PLAYERS);
    localparam int c_side_int = 1 << IMG_BITS;
    localparam logic [10:0]   c_img_side     = c_side_int[10:0];
    localparam logic [c_pw:0] c_num_players  = NUM_PLAYERS[c_pw:0];

    state_t            r_state;
    logic [1:0]        r_dim;
    logic [c_pw-1:0]   r_player;
    logic              w_id_ok;
    logic              w_accept;
    logic              w_step;
    logic [9:0]        w_vr;
    logic [9:0]        w_vc;
    logic              w_in_window;
    logic              r_win1;
    logic              r_win2;
    logic [1:0]        r_dim1;
    logic [1:0]        r_dim2;
    logic              r_dis1;
    logic              r_dis2;

    assign w_id_ok  = ({1'b0, winner_id} < c_num_players);
    assign w_accept = (r_state == c_st_idle) && winner_valid && w_id_ok && !game_restart;

    victory_fade_timer #(
        .FADE_FRAMES (FADE_FRAMES)
    ) u_fade_timer (
        .clk            (clk),
        .rst            (reset),
        .i_pixel_row    (pixel_row),
        .i_pixel_column (pixel_column),
        .i_enable       (r_state == c_st_reveal),
        .i_clear        (w_accept || game_restart),
        .o_step         (w_step)
    );

    // Restart wins over everything, including a same-cycle winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_dim    <= c_dim_max;
            r_player <= '0;
        end else if (game_restart) begin
            r_state <= c_st_idle;
            r_dim   <= c_dim_max;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_player <= winner_id;
                        r_dim    <= c_dim_max;
                        r_state  <= c_st_reveal;
                    end
                end
                c_st_reveal: begin
                    if (w_step) begin
                        r_dim <= r_dim - 2'd1;
                        if (r_dim == 2'd1) begin
                            r_state <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    r_dim <= 2'd0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_vr        = pixel_row >> SCALE_SHIFT;
    assign w_vc        = pixel_column >> SCALE_SHIFT;
    assign w_in_window = ({1'b0, w_vr} < c_img_side) && ({1'b0, w_vc} < c_img_side);

    // Window, dim and enable travel two stages to line up with the ROM word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr           <= '0;
            r_win1             <= 1'b0;
            r_win2             <= 1'b0;
            r_dim1             <= 2'd0;
            r_dim2             <= 2'd0;
            r_dis1             <= 1'b0;
            r_dis2             <= 1'b0;
            data_out_v_s       <= 8'h00;
            dis_victory_screen <= 1'b0;
        end else begin
            rom_addr           <= {r_player, w_vr[IMG_BITS-1:0], w_vc[IMG_BITS-1:0]};
            r_win1             <= w_in_window;
            r_dim1             <= r_dim;
            r_dis1             <= (r_state != c_st_idle);
            r_win2             <= r_win1;
            r_dim2             <= r_dim1;
            r_dis2             <= r_dis1;
            data_out_v_s       <= (r_dis2 && r_win2) ? dim_shift(rom_data, r_dim2) : BG_COLOR;
            dis_victory_screen <= r_dis2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_victory_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_victory_overlay
// Brief    : Directed self-checking bench for victory_overlay (3 players,
//            two frames per fade step).
// Revision : 1.0 - initial release
// ============================================================================
module tb_victory_overlay;

    localparam int         NP = 3;
    localparam int         IB = 7;
    localparam int         SS = 2;
    localparam int         FF = 2;
    localparam logic [7:0] BG = 8'h5A;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        winner_valid = 1'b0;
    logic [1:0]  winner_id    = 2'd0;
    logic        game_restart = 1'b0;
    logic [9:0]  pixel_row    = 10'd1;
    logic [9:0]  pixel_column = 10'd1;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data     = 8'h00;
    logic [7:0]  rom_word     = 8'hFF;
    logic [7:0]  data_out_v_s;
    logic        dis_victory_screen;

    int n_checks = 0;
    int n_fail   = 0;

    victory_overlay #(
        .NUM_PLAYERS (NP),
        .IMG_BITS    (IB),
        .SCALE_SHIFT (SS),
        .FADE_FRAMES (FF),
        .BG_COLOR    (BG)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .winner_valid       (winner_valid),
        .winner_id          (winner_id),
        .game_restart       (game_restart),
        .pixel_row          (pixel_row),
        .pixel_column       (pixel_column),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .data_out_v_s       (data_out_v_s),
        .dis_victory_screen (dis_victory_screen)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous ROM returning a bench-controlled word.
    always @(posedge clk) rom_data <= rom_word;

    task automatic tick_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input logic [9:0] r, input logic [9:0] c);
        pixel_row    = r;
        pixel_column = c;
        tick_clk(3);
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_row = 10'd0; pixel_column = 10'd0;
            tick_clk(1);
            pixel_row = 10'd1; pixel_column = 10'd1;
            tick_clk(1);
        end
    endtask

    task automatic pulse_winner(input logic [1:0] id);
        winner_id    = id;
        winner_valid = 1'b1;
        tick_clk(1);
        winner_valid = 1'b0;
    endtask

    task automatic test_reset;
        tick_clk(2);
        n_checks++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr); end
        n_checks++; if (data_out_v_s !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out_v_s); end
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL reset_dis: got %b expected 0", dis_victory_screen); end
        reset = 1'b0;
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL idle_data: got %h expected %h", data_out_v_s, BG); end
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL idle_dis: got %b expected 0", dis_victory_screen); end
        n_checks++; if (rom_addr !== 16'h0081) begin n_fail++; $display("FAIL idle_rom_addr: got %h expected 0081", rom_addr); end
    endtask

    task automatic test_reveal;
        rom_word = 8'hFF;
        pulse_winner(2'd1);
        probe(10'd4, 10'd4);
        n_checks++; if (dis_victory_screen !== 1'b1) begin n_fail++; $display("FAIL reveal_dis: got %b expected 1", dis_victory_screen); end
        n_checks++; if (rom_addr !== 16'h4081) begin n_fail++; $display("FAIL reveal_rom_addr: got %h expected 4081", rom_addr); end
        n_checks++; if (data_out_v_s !== 8'h00) begin n_fail++; $display("FAIL dim3_data: got %h expected 00", data_out_v_s); end
        frame_ticks(2);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h24) begin n_fail++; $display("FAIL dim2_data: got %h expected 24", data_out_v_s); end
        frame_ticks(2);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h6D) begin n_fail++; $display("FAIL dim1_data: got %h expected 6d", data_out_v_s); end
        rom_word = 8'hB6;
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h49) begin n_fail++; $display("FAIL dim1_b6_data: got %h expected 49", data_out_v_s); end
        rom_word = 8'hFF;
        frame_ticks(1);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h6D) begin n_fail++; $display("FAIL five_ticks_data: got %h expected 6d", data_out_v_s); end
        frame_ticks(1);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'hFF) begin n_fail++; $display("FAIL hold_data: got %h expected ff", data_out_v_s); end
    endtask

    task automatic test_window;
        pixel_row = 10'd0; pixel_column = 10'd513;
        tick_clk(2);
        n_checks++; if (data_out_v_s !== 8'hFF) begin n_fail++; $display("FAIL latency_early: got %h expected ff", data_out_v_s); end
        tick_clk(1);
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL col513_data: got %h expected %h", data_out_v_s, BG); end
        probe(10'd600, 10'd0);
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL row600_data: got %h expected %h", data_out_v_s, BG); end
        probe(10'd0, 10'd512);
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL col512_data: got %h expected %h", data_out_v_s, BG); end
        probe(10'd511, 10'd511);
        n_checks++; if (data_out_v_s !== 8'hFF) begin n_fail++; $display("FAIL corner_data: got %h expected ff", data_out_v_s); end
        n_checks++; if (rom_addr !== 16'h7FFF) begin n_fail++; $display("FAIL corner_rom_addr: got %h expected 7fff", rom_addr); end
    endtask

    task automatic test_hold_ignore;
        pulse_winner(2'd0);
        probe(10'd4, 10'd4);
        n_checks++; if (rom_addr[15:14] !== 2'd1) begin n_fail++; $display("FAIL hold_keep_player: got %0d expected 1", rom_addr[15:14]); end
        n_checks++; if (dis_victory_screen !== 1'b1) begin n_fail++; $display("FAIL hold_dis: got %b expected 1", dis_victory_screen); end
        game_restart = 1'b1;
        tick_clk(1);
        game_restart = 1'b0;
        tick_clk(3);
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL restart_dis: got %b expected 0", dis_victory_screen); end
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL restart_data: got %h expected %h", data_out_v_s, BG); end
    endtask

    task automatic test_simultaneous;
        winner_id    = 2'd0;
        winner_valid = 1'b1;
        game_restart = 1'b1;
        tick_clk(1);
        winner_valid = 1'b0;
        game_restart = 1'b0;
        probe(10'd4, 10'd4);
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL simul_dis: got %b expected 0", dis_victory_screen); end
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL simul_data: got %h expected %h", data_out_v_s, BG); end
    endtask

    task automatic test_out_of_range;
        pulse_winner(2'd3);
        probe(10'd4, 10'd4);
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL oor_dis: got %b expected 0", dis_victory_screen); end
        n_checks++; if (data_out_v_s !== BG) begin n_fail++; $display("FAIL oor_data: got %h expected %h", data_out_v_s, BG); end
    endtask

    task automatic test_held_origin;
        rom_word = 8'hFF;
        pulse_winner(2'd2);
        pixel_row = 10'd0; pixel_column = 10'd0;
        tick_clk(4);
        pixel_row = 10'd1; pixel_column = 10'd1;
        tick_clk(1);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h00) begin n_fail++; $display("FAIL held_one_tick: got %h expected 00", data_out_v_s); end
        n_checks++; if (rom_addr !== 16'h8081) begin n_fail++; $display("FAIL held_rom_addr: got %h expected 8081", rom_addr); end
        frame_ticks(1);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h24) begin n_fail++; $display("FAIL held_then_tick: got %h expected 24", data_out_v_s); end
    endtask

    task automatic test_reset_mid_reveal;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL async_rom_addr: got %h expected 0000", rom_addr); end
        n_checks++; if (data_out_v_s !== 8'h00) begin n_fail++; $display("FAIL async_data: got %h expected 00", data_out_v_s); end
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL async_dis: got %b expected 0", dis_victory_screen); end
        tick_clk(1);
        reset = 1'b0;
        probe(10'd4, 10'd4);
        n_checks++; if (dis_victory_screen !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", dis_victory_screen); end
        pulse_winner(2'd1);
        probe(10'd4, 10'd4);
        n_checks++; if (data_out_v_s !== 8'h00) begin n_fail++; $display("FAIL post_reset_dim3: got %h expected 00", data_out_v_s); end
        n_checks++; if (rom_addr !== 16'h4081) begin n_fail++; $display("FAIL post_reset_rom_addr: got %h expected 4081", rom_addr); end
    endtask

    initial begin
        test_reset();
        test_reveal();
        test_window();
        test_hold_ignore();
        test_simultaneous();
        test_out_of_range();
        test_held_origin();
        test_reset_mid_reveal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
